deadband_tracker: RTL
=====================

DEADBAND_TRACKER -- requirements
Module: deadband_tracker

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits (4..16).
REQ-002 Parameter N_CH, default 4, channel count, power of two 2..16; CH_W = log2(N_CH).
REQ-003 Parameter THR_RST, default 2, threshold value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  block enable; low = freeze (no accept, no writes).
REQ-007 in_valid  input  1  sample strobe; a sample is accepted when in_valid && ena.
REQ-008 in_ch  input  CH_W  channel index of the sample.
REQ-009 in_data  input  DATA_W  unsigned sample value.
REQ-010 thr_we  input  1  threshold write strobe (effective only when ena=1).
REQ-011 thr_data  input  DATA_W  new threshold value.
REQ-012 cnt_clr  input  1  event-counter clear strobe.
REQ-013 out_event  output  1  one-cycle pulse flagging a change event.
REQ-014 out_ch  output  CH_W  channel of the last event.
REQ-015 out_value  output  DATA_W  sample value of the last event.
REQ-016 out_delta  output  DATA_W+1  signed two's-complement (new - old) of the last event.
REQ-017 evt_count  output  16  saturating count of events since reset/clear.

Function
REQ-018 Per channel the block SHALL hold stored value S[ch] (DATA_W) and primed bit P[ch]; one shared threshold THR (DATA_W).
REQ-019 On an accepted sample, d = in_data - S[in_ch] SHALL be computed at DATA_W+1 bits signed, no wrap; |d| is unsigned DATA_W.
REQ-020 An event SHALL occur when P[in_ch]=0 (first sample) or |d| > THR (strict; |d| = THR is no event).
REQ-021 On event: S[in_ch] <= in_data, P[in_ch] <= 1; on no event, S and P SHALL be unchanged.
REQ-022 Latency: out_event SHALL assert exactly the cycle after acceptance, for one cycle, with out_ch/out_value/out_delta registered on the same edge.
REQ-023 First-sample events SHALL report out_delta = 0.
REQ-024 Without an event, out_event SHALL be 0 and out_ch/out_value/out_delta SHALL hold their last event values.
REQ-025 Back-to-back samples (one per cycle, any channel, including same channel) SHALL be accepted at full rate; each compares against S as updated by all prior accepted samples.
REQ-026 thr_we SHALL update THR on the clock edge; a sample accepted in the same cycle SHALL use the old THR.
REQ-027 THR = 0: any nonzero change triggers; THR = 2^DATA_W-1: only first samples trigger.
REQ-028 ena=0: no sample accepted, thr_we ignored, out_event = 0, all state held; cnt_clr still honoured.
REQ-029 evt_count SHALL increment by 1 per event and saturate at 0xFFFF (no wrap).
REQ-030 cnt_clr with an event in the same cycle SHALL yield evt_count = 1; cnt_clr alone yields 0.

Reset
REQ-031 When rst_n=0 at a clock edge: all S = 0, all P = 0, THR = THR_RST, out_event = 0, out_ch = 0, out_value = 0, out_delta = 0, evt_count = 0.
REQ-032 A sample or thr_we presented in a reset cycle SHALL be discarded; an event pulse pending from the preceding cycle SHALL be suppressed (out_event = 0 after the reset edge).
REQ-033 Reset SHALL take priority over ena, in_valid, thr_we and cnt_clr.

Verification (defaults DATA_W=8, N_CH=4, THR_RST=2)
REQ-034 After reset, ch0 sample 0x10 -> next cycle out_event=1, out_ch=0, out_value=0x10, out_delta=0, evt_count=1.
REQ-035 Then ch0 0x12 (|d|=2) -> no event, S[0] stays 0x10; then ch0 0x13 -> event, out_delta=+3 (0x003), evt_count=2.
REQ-036 ch1 primed at 0xFF, then ch1 0x00 -> event, out_delta = -255 (0x101), out_value=0x00.
REQ-037 thr_we=1, thr_data=0 together with ch0 sample differing by 1 -> no event (old THR=2); next ch0 sample differing by 1 -> event.
REQ-038 ch2 samples 0x20, 0x30, 0x31 on consecutive cycles -> out_event 1,1,0 on the following three cycles; out_delta=0 then +16.
REQ-039 rst_n=0 for one cycle mid-stream with in_valid=1 -> all outputs 0, evt_count=0, next ch0 sample 0x05 reports first-sample event with out_delta=0.

Source files
------------

// File: rtl/deadband_tracker.sv
// Multi-channel deadband change tracker.
// Each channel keeps the value it last reported. A new sample raises an event
// when it is the channel's first sample or when it differs from that value by
// more than the shared threshold. Events are reported one cycle after
// acceptance and counted in a saturating 16-bit counter.
module deadband_tracker #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned THR_RST = 2,
  localparam int unsigned CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              thr_we,
  input  logic [DATA_W-1:0] thr_data,
  input  logic              cnt_clr,
  output logic              out_event,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W:0]   out_delta,
  output logic [15:0]       evt_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DELTA_W = DATA_W + 1;

  // Per-channel reported value, primed flags and the shared threshold
  logic [DATA_W-1:0] s_q [N_CH];
  logic [N_CH-1:0]   p_q;
  logic [DATA_W-1:0] thr_q;

  // Combinational compare path for the sample presented this cycle
  logic              accept_c;
  logic [DATA_W-1:0] cur_c;
  logic              primed_c;
  logic [DELTA_W-1:0] delta_c;
  logic [DELTA_W-1:0] neg_delta_c;
  logic [DATA_W-1:0] abs_c;
  logic              event_c;

  // Signed difference against the stored value and the event decision
  always_comb begin
    accept_c    = in_valid & ena;
    cur_c       = s_q[in_ch];
    primed_c    = p_q[in_ch];
    delta_c     = {1'b0, in_data} - {1'b0, cur_c};
    neg_delta_c = DELTA_W'(0) - delta_c;
    abs_c       = delta_c[DATA_W] ? neg_delta_c[DATA_W-1:0] : delta_c[DATA_W-1:0];
    event_c     = accept_c & (~primed_c | (abs_c > thr_q));
  end

  // Channel store: only an event moves the reference value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        s_q[i] <= '0;
      end
      p_q <= '0;
    end else if (event_c) begin
      s_q[in_ch] <= in_data;
      p_q[in_ch] <= 1'b1;
    end
  end

  // Threshold register; a same-cycle sample still sees the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q <= DATA_W'(THR_RST);
    end else if (ena && thr_we) begin
      thr_q <= thr_data;
    end
  end

  // Event report registers; payload holds between events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_event <= 1'b0;
      out_ch    <= '0;
      out_value <= '0;
      out_delta <= '0;
    end else begin
      out_event <= event_c;
      if (event_c) begin
        out_ch    <= in_ch;
        out_value <= in_data;
        out_delta <= primed_c ? delta_c : '0;
      end
    end
  end

  // Saturating event counter; a clear coinciding with an event leaves one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_count <= '0;
    end else if (cnt_clr) begin
      evt_count <= event_c ? CNT_W'(1) : '0;
    end else if (event_c && (evt_count != {CNT_W{1'b1}})) begin
      evt_count <= evt_count + CNT_W'(1);
    end
  end

endmodule
